dm_responder: RTL and testbench
===============================

# dm_responder

Multi-cycle, word-organised data-memory responder on the CPU's load/store bus. It replaces the zero-latency data memory, so the core can be exercised against wait-stated memory. It accepts one request at a time over a req/ack handshake and applies byte-enabled writes. It flags misaligned or out-of-range accesses, and clears its storage after reset with a sequential sweep.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words; must be a power of two, at least 4.
- WAIT, 2: wait cycles inserted between acceptance and response, 0–15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request valid; sampled only while idle.
- we  in  1  1 = store, 0 = load.
- addr  in  32  byte address; must be word-aligned.
- wdata  in  32  store data.
- be  in  4  byte enables for stores; be[i] covers wdata[8i+7:8i]. Ignored for loads.
- rdata  out  32  load data; valid only while ack = 1, otherwise 0.
- ack  out  1  one-cycle response strobe.
- err  out  1  error flag; valid with ack.
- busy  out  1  high whenever a new request will not be accepted.

## Operation
- States: CLEAR, IDLE, WAIT, RESP.
- **CLEAR** (entered on reset):
  - Writes 0 to word clr_idx, then increments clr_idx.
  - After word DEPTH-1, goes to IDLE. This takes DEPTH cycles.
  - busy = 1 throughout.
- **IDLE**, req = 1:
  - Latch we, addr, wdata and be.
  - Set err_q if addr[1:0] != 0, or if addr[31:2] >= DEPTH.
  - If err_q is set, or WAIT = 0, go to RESP. Otherwise load wcnt = WAIT-1 and go to WAIT.
- **IDLE**, req = 0: remain in IDLE.
- **WAIT**: decrement wcnt. When wcnt = 0, go to RESP.
- **Entering RESP** (on the transition edge):
  - Non-error store: merge enabled bytes into word addr[31:2].
  - Non-error load: rdata register loaded from word addr[31:2].
  - Error: nothing is written, and rdata = 0.
- **RESP**:
  - ack = 1 and err = err_q for exactly one cycle.
  - Then unconditionally go to IDLE.
- Store with be = 4'b0000: memory unchanged; normal ack with err = 0.
- Inputs other than req are don't-care outside IDLE. Latched values are used throughout.
- The initiator must drop req in the cycle after ack. If req is still high in IDLE, it is a new request.
- Only the low log2(DEPTH)+2 address bits index storage. Upper address bits only feed the range check.

## Timing
- Reset values: state = CLEAR, clr_idx = 0, ack = 0, err = 0, rdata = 0, busy = 1.
- Latency: req sampled at edge N → ack high during cycle N+WAIT+1.
- Error responses always have latency 1, independent of WAIT.
- Minimum request spacing is WAIT+2 cycles, since RESP always returns to IDLE.
- busy = 1 in CLEAR, WAIT and RESP; busy = 0 only in IDLE.
- Load-after-store to the same word returns the newly stored data, because the store commits on RESP entry.
- Reset asserted mid-operation:
  - Aborts the transaction; no ack is issued.
  - A store still in WAIT is not committed.
  - Restarts the CLEAR sweep from word 0.
- clr_idx is a log2(DEPTH)-bit counter. The sweep terminates on the all-ones value, with no wrap to 0.

## Structure
- Shared package cpu_mem_pkg holds:
  - the state enum (CLEAR, IDLE, WAIT, RESP);
  - WORD_W = 32;
  - function word_merge(old, new, be) returning the byte-merged word.
- One sub-module, dm_array: a single-port synchronous storage array (DEPTH × 32) with write enable and 4-bit byte write mask.
  - CLEAR drives it with a full mask and zero data.
- The FSM, wait counter and clear counter live in dm_responder.

## Test plan
- **Reset sweep:** reset 1 cycle, DEPTH = 256 → busy high for exactly 256 cycles, then low; a load of addr 0x40 returns 0x00000000 with err = 0.
- **Store/load latency:** WAIT = 2, store 0xDEADBEEF to 0x10 with be = 4'hF, then load 0x10 → each ack arrives 3 cycles after req; rdata = 0xDEADBEEF.
- **Byte enables:** store 0x11223344 to 0x20 with be = 4'hF, then 0xAABBCCDD with be = 4'b0101, then load → 0x11BB33DD.
- **Errors:** load from addr 0x13 → ack after 1 cycle, err = 1, rdata = 0. Store to 0x400 (word 256, DEPTH = 256) → err = 1 and memory unchanged.
- **Reset mid-WAIT:** store 0xCAFEF00D to 0x8, assert reset one cycle after acceptance → no ack; after the sweep, a load of 0x8 returns 0.
- **WAIT = 0 back-to-back:** req held high continuously → ack every 2nd cycle, busy alternating 0/1.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the wait-stated data-memory responder.
//   dm_state_e  : responder FSM states
//   WORD_W      : storage word width
//   word_merge  : byte-enabled merge of a new word into an old word
package cpu_mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dm_state_e;

    function automatic logic [WORD_W-1:0] word_merge(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [3:0]        be
    );
        logic [WORD_W-1:0] r;
        r = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dm_array.sv
// Single-port synchronous word array with byte write mask.
// Ports:
//   clk    in  clock
//   en     in  access enable (read or write this cycle)
//   we     in  1 = write (masked by wmask), 0 = read
//   addr   in  word index
//   wdata  in  write data
//   wmask  in  byte write mask, bit i covers wdata[8i+7:8i]
//   rdata  out registered read data, holds until the next read
module dm_array
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [3:0]        wmask,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] merged_d;
    logic [WORD_W-1:0] rdata_q;
    logic [WORD_W-1:0] rdata_d;

    always_comb begin
        merged_d = word_merge(mem_q[addr], wdata, wmask);
        rdata_d  = rdata_q;
        if (en && !we) rdata_d = mem_q[addr];
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (en && we) mem_q[addr] <= merged_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// Wait-stated data-memory responder for the CPU load/store bus.
// One request at a time over req/ack, byte-enabled stores, error flag for
// misaligned or out-of-range addresses, zero-fill sweep after reset.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   req, we         request valid, 1 = store / 0 = load
//   addr, wdata, be byte address, store data, store byte enables
//   rdata           load data during ack, else 0
//   ack, err        one-cycle response strobe and its error flag
//   busy            high whenever a new request will not be accepted
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | zero-fill sweep, one word per cycle, word 0..DEPTH-1
// ST_IDLE  | ready; a high req is latched and range-checked
// ST_WAIT  | counting wait cycles; memory accessed on exit
// ST_RESP  | ack (and err) high for one cycle, then back to idle
module dm_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    dm_state_e         state_q, state_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              we_q, we_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              err_q, err_d;

    logic              err_now;
    logic              mem_en;
    logic              mem_en_g;
    logic              mem_we;
    logic [AW-1:0]     mem_idx;
    logic [WORD_W-1:0] mem_wdata;
    logic [3:0]        mem_mask;
    logic [WORD_W-1:0] mem_rdata;

    // Upper address bits only take part in the range check.
    assign err_now = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            wcnt_q    <= '0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            wcnt_q    <= wcnt_d;
            we_q      <= we_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        wcnt_d    = wcnt_q;
        we_d      = we_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        err_d     = err_q;
        mem_en    = 1'b0;
        mem_we    = we_q;
        mem_idx   = idx_q;
        mem_wdata = wdata_q;
        mem_mask  = be_q;

        case (state_q)
            ST_CLEAR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_idx   = clr_idx_q;
                mem_wdata = '0;
                mem_mask  = 4'hF;
                // Sweep stops on the last word; the index holds, no wrap.
                if (clr_idx_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    idx_d   = addr[AW+1:2];
                    wdata_d = wdata;
                    be_d    = be;
                    err_d   = err_now;
                    if (err_now || WAIT == 0) begin
                        state_d = ST_RESP;
                        // Zero-wait access uses the live inputs, since the
                        // latches only update on this same edge.
                        if (!err_now) begin
                            mem_en    = 1'b1;
                            mem_we    = we;
                            mem_idx   = addr[AW+1:2];
                            mem_wdata = wdata;
                            mem_mask  = be;
                        end
                    end else begin
                        wcnt_d  = 4'(WAIT - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    mem_en  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // A reset arriving on the commit edge must not let the store land.
    assign mem_en_g = mem_en && !reset;

    always_comb begin
        ack   = (state_q == ST_RESP);
        err   = ack && err_q;
        busy  = (state_q != ST_IDLE);
        rdata = (ack && !err_q && !we_q) ? mem_rdata : '0;
    end

    dm_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (mem_en_g),
        .we    (mem_we),
        .addr  (mem_idx),
        .wdata (mem_wdata),
        .wmask (mem_mask),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk_rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we, ack, err, busy;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic        req0, we0, ack0, err0, busy0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  be0;

    int n_checks = 0;
    int n_errors = 0;
    exp_t q[$];
    exp_t q0[$];

    always #5 clk = ~clk;

    dm_responder #(.DEPTH(256), .WAIT(2)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
    );

    dm_responder #(.DEPTH(16), .WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0),
        .wdata(wdata0), .be(be0), .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: every ack pops one expected response.
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ack: got ack with no request pending, expected none");
            end else begin
                exp_t e;
                e = q.pop_front();
                check("resp_err", 32'(err), 32'(e.err));
                if (e.chk_rd) check("resp_rdata", rdata, e.rdata);
            end
        end
    end

    always @(negedge clk) begin
        if (ack0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ack0: got ack with no request pending, expected none");
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("resp0_err", 32'(err0), 32'(e.err));
                if (e.chk_rd) check("resp0_rdata", rdata0, e.rdata);
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy !== 1'b0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic count_busy(input string name, input int exp_n);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check(name, n, exp_n);
    endtask

    task automatic do_req(input string name, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          input logic [31:0] exp_rd, input bit exp_err,
                          input bit chk_rd, input int exp_lat);
        exp_t e;
        int   lat;
        wait_idle();
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        e.rdata = exp_rd; e.err = exp_err; e.chk_rd = chk_rd;
        q.push_back(e);
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (ack !== 1'b1 && lat < 50);
        check({name, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   k;
        reset = 1'b1;
        req = 0; we = 0; addr = 0; wdata = 0; be = 0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; be0 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        count_busy("sweep_cycles", 256);

        do_req("ld_40", 0, 32'h40, 32'h0, 4'h0, 32'h0, 0, 1, 3);
        do_req("st_10", 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0, 3);
        do_req("ld_10", 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 1, 3);

        do_req("st_20a", 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0, 0, 3);
        do_req("st_20b", 1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 0, 0, 3);
        do_req("ld_20", 0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 0, 1, 3);

        do_req("ld_13", 0, 32'h13, 32'h0, 4'h0, 32'h0, 1, 1, 1);
        do_req("st_0", 1, 32'h0, 32'h01020304, 4'hF, 32'h0, 0, 0, 3);
        do_req("st_400", 1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 1, 1);
        do_req("ld_0", 0, 32'h0, 32'h0, 4'h0, 32'h01020304, 0, 1, 3);
        do_req("st_hi", 1, 32'h8000_0010, 32'h0, 4'hF, 32'h0, 1, 1, 1);
        do_req("st_be0", 1, 32'h10, 32'h0, 4'h0, 32'h0, 0, 0, 3);
        do_req("ld_10b", 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 1, 3);
        do_req("st_3fc", 1, 32'h3FC, 32'h13579BDF, 4'hF, 32'h0, 0, 0, 3);
        do_req("ld_3fc", 0, 32'h3FC, 32'h0, 4'h0, 32'h13579BDF, 0, 1, 3);

        // Zero-wait instance: store, then req held high for back-to-back loads.
        k = 0;
        @(negedge clk);
        while (busy0 !== 1'b0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        req0 = 1; we0 = 1; addr0 = 32'h4; wdata0 = 32'h5A5A1234; be0 = 4'hF;
        e.rdata = 32'h0; e.err = 0; e.chk_rd = 0;
        q0.push_back(e);
        @(posedge clk);
        #1 req0 = 0;
        @(negedge clk);
        check("st0_ack", 32'(ack0), 32'd1);
        @(negedge clk);
        check("b2b_idle", 32'(busy0), 32'd0);
        req0 = 1; we0 = 0; addr0 = 32'h4;
        for (int i = 0; i < 5; i++) begin
            e.rdata = 32'h5A5A1234; e.err = 0; e.chk_rd = 1;
            q0.push_back(e);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("b2b_ack", 32'(ack0), 32'((i % 2) == 0));
            check("b2b_busy", 32'(busy0), 32'((i % 2) == 0));
            if (i == 9) req0 = 0;
        end

        // Reset while a store is waiting: no ack, sweep restarts, word cleared.
        wait_idle();
        req = 1; we = 1; addr = 32'h8; wdata = 32'hCAFEF00D; be = 4'hF;
        @(posedge clk);
        #1 req = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        count_busy("sweep2_cycles", 256);
        do_req("ld_8", 0, 32'h8, 32'h0, 4'h0, 32'h0, 0, 1, 3);
        do_req("ld_20c", 0, 32'h20, 32'h0, 4'h0, 32'h0, 0, 1, 3);

        repeat (3) @(negedge clk);
        check("q_drained", q.size(), 32'd0);
        check("q0_drained", q0.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
